// File: rtl/fft_mdc_pkg.sv
// Shared types and default constants for the 32-point radix-2 MDC FFT sequencer.
package fft_mdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned FRAME_PAIRS   = 16;
  localparam int unsigned PAIR_IDX_W    = 4;
  localparam int unsigned PIPE_LAT_DEF  = 40;
  localparam int unsigned ROM16_LAT_DEF = 16;
  localparam int unsigned CODE_W_DEF    = 7;

  // In-flight marker travelling alongside each sample pair.
  typedef struct packed {
    logic valid;
    logic first;
  } token_t;

endpackage

// File: rtl/fft_token_pipe.sv
// Enable-gated {valid, first} delay line matching the FFT datapath latency,
// plus a count of valid tokens currently inside it.
module fft_token_pipe
  import fft_mdc_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  token_t                         tok_in,
  output token_t                         tok_out,
  output logic [$clog2(DEPTH+1)-1:0]     inflight
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  token_t [DEPTH-1:0] line;
  logic               enter;
  logic               leave;

  assign tok_out = line[DEPTH-1];
  assign enter   = en & tok_in.valid;
  assign leave   = en & line[DEPTH-1].valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (en) begin
      line <= {line[DEPTH-2:0], tok_in};
    end
  end

  // Simultaneous entry and exit leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({enter, leave})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: rtl/fft_mdc_ctrl.sv
// Sequencer for the 32-point radix-2 MDC FFT: commutator code, stage-1 ROM
// address, pipeline enable and aligned output flags. FFT_MDC_CTRL_STATUS_EN adds frame/stall counters.
module fft_mdc_ctrl
  import fft_mdc_pkg::*;
#(
  parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF,
  parameter int unsigned ROM16_LAT = ROM16_LAT_DEF,
  parameter int unsigned CODE_W    = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_first,
  output logic              pipe_en,
  output logic [CODE_W-1:0] state_code,
  output logic [3:0]        rom_16_counter,
  output logic              out_valid,
  output logic              out_first,
  output logic              busy,
  output logic              sync_err
`ifdef FFT_MDC_CTRL_STATUS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned INF_W = $clog2(PIPE_LAT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] cnt;
  logic [CODE_W-1:0] cnt_nxt;
  logic              sync_err_nxt;
  logic              stall_c;
  logic              boundary;
  token_t            tok_in;
  token_t            tok_tail;
  logic [INF_W-1:0]  inflight;

  assign boundary = (cnt[PAIR_IDX_W-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pipe_en      = 1'b0;
    tok_in       = '0;
    sync_err_nxt = 1'b0;
    stall_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_first) begin
          pipe_en      = 1'b1;
          tok_in.valid = 1'b1;
          tok_in.first = 1'b1;
          cnt_nxt      = cnt + CODE_W'(1);
          state_nxt    = RUN;
        end
      end
      RUN: begin
        pipe_en = in_valid;
        if (in_valid) begin
          // An off-boundary in_first is flagged but treated as ordinary data.
          tok_in.valid = 1'b1;
          tok_in.first = in_first & boundary;
          sync_err_nxt = in_first & ~boundary;
          cnt_nxt      = cnt + CODE_W'(1);
        end else if (boundary) begin
          state_nxt = FLUSH;
        end else begin
          stall_c = 1'b1;
        end
      end
      FLUSH: begin
        // Keep clocking invalid tokens through until the pipeline is empty.
        pipe_en = 1'b1;
        if (in_valid && in_first) begin
          tok_in.valid = 1'b1;
          tok_in.first = boundary;
          sync_err_nxt = ~boundary;
          cnt_nxt      = cnt + CODE_W'(1);
          state_nxt    = RUN;
        end else if (inflight == '0) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  fft_token_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tok (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pipe_en),
    .tok_in   (tok_in),
    .tok_out  (tok_tail),
    .inflight (inflight)
  );

  assign state_code     = cnt;
  assign rom_16_counter = 4'(cnt - CODE_W'(ROM16_LAT));
  assign busy           = (state != IDLE);
  assign out_valid      = pipe_en & tok_tail.valid;
  assign out_first      = pipe_en & tok_tail.valid & tok_tail.first;

`ifdef FFT_MDC_CTRL_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_first) begin
        frame_cnt <= frame_cnt + 16'(1);
      end
      if (stall_c && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'(1);
      end
    end
  end
`endif

endmodule
